sb_cfg_gen2: RTL and testbench

Second-generation fabric switch box with an integrated, address-filtered configuration loader. Four directional channels of CHN_WIDTH tracks meet here, and each output track is driven by a 2-bit select. A serial daisy-chained loader writes a shadow configuration and commits it atomically, so the switch never routes a partially shifted configuration. The block sits on the fabric config chain between CLB tiles, and its config ports connect head-to-tail.

---
 rtl/sb_cfg_pkg.sv | 29 ++
 rtl/sb_cfg_loader.sv | 133 +++++++++++++
 rtl/sb_cfg_gen2.sv | 76 +++++++
 tb/tb_sb_cfg_gen2.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/sb_cfg_pkg.sv
// Shared side indices, select encodings and loader state encoding for the
// sb_cfg_gen2 switch box and its configuration loader.
package sb_cfg_pkg;

  localparam int NUM_SIDES = 4;
  localparam int SIDE_N    = 0;
  localparam int SIDE_E    = 1;
  localparam int SIDE_S    = 2;
  localparam int SIDE_W    = 3;

  localparam logic [1:0] SEL_OFF = 2'd0;
  localparam logic [1:0] SEL_CW1 = 2'd1;
  localparam logic [1:0] SEL_CW2 = 2'd2;
  localparam logic [1:0] SEL_CW3 = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_LOAD,
    ST_PAR,
    ST_COMMIT
  } loader_state_t;

  // Side reached by stepping clockwise 'step' positions from 'side'.
  function automatic int cwSide(input int side, input int step);
    return (side + step) % NUM_SIDES;
  endfunction

endpackage

// File: rtl/sb_cfg_loader.sv
// Serial, address-filtered configuration loader with shadow/active registers.
// Defining SB_CFG_PARITY_EN adds a trailing even-parity bit and a sticky error.
module sb_cfg_loader
  import sb_cfg_pkg::*;
#(
  parameter int ID_WIDTH = 3,
  parameter int ID       = 5,
  parameter int CFG_SIZE = 128
) (
  input  logic                clk,
  input  logic                crst_n,
  input  logic                i_start,
  input  logic                i_bit,
  output logic                o_start,
  output logic                o_bit,
  output logic                o_valid,
  output logic                o_busy,
  output logic                o_err,
  output logic [CFG_SIZE-1:0] o_cfg
);

  localparam int                CNT_W     = $clog2(CFG_SIZE + ID_WIDTH + 1);
  localparam logic [ID_WIDTH-1:0] HDR_ID    = ID_WIDTH'(ID);
  localparam logic [ID_WIDTH-1:0] HDR_BCAST = '1;

  loader_state_t       r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [ID_WIDTH-1:0] r_hdr;
  logic [CFG_SIZE-1:0] r_shadow;
  logic [CFG_SIZE-1:0] r_active;
  logic                r_valid;
  logic                r_fwdStart;
  logic                r_fwdBit;
`ifdef SB_CFG_PARITY_EN
  logic                r_par;
  logic                r_err;
`endif

  logic [ID_WIDTH-1:0] w_hdrNext;
  logic                w_hdrMatch;

  assign w_hdrNext  = (r_hdr << 1) | ID_WIDTH'(i_bit);
  assign w_hdrMatch = (w_hdrNext == HDR_ID) || (w_hdrNext == HDR_BCAST);

  always_ff @(posedge clk or negedge crst_n) begin
    if (!crst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_hdr      <= '0;
      r_shadow   <= '0;
      r_active   <= '0;
      r_valid    <= 1'b0;
      r_fwdStart <= 1'b0;
      r_fwdBit   <= 1'b0;
`ifdef SB_CFG_PARITY_EN
      r_par      <= 1'b0;
      r_err      <= 1'b0;
`endif
    end else begin
      r_fwdStart <= i_start;
      r_fwdBit   <= i_bit;

      if (r_state == ST_COMMIT) begin
        r_active <= r_shadow;
        r_valid  <= 1'b1;
      end

      // A start bit always opens a new header, whatever frame was in flight.
      if (i_start) begin
        r_state  <= ST_HDR;
        r_hdr    <= ID_WIDTH'(i_bit);
        r_cnt    <= CNT_W'(1);
        r_shadow <= '0;
`ifdef SB_CFG_PARITY_EN
        r_par    <= 1'b0;
`endif
      end else begin
        case (r_state)
          ST_IDLE: ;
          ST_HDR: begin
            r_hdr <= w_hdrNext;
            if (r_cnt == CNT_W'(ID_WIDTH - 1)) begin
              r_cnt   <= '0;
              r_state <= w_hdrMatch ? ST_LOAD : ST_IDLE;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          ST_LOAD: begin
            r_shadow <= {r_shadow[CFG_SIZE-2:0], i_bit};
`ifdef SB_CFG_PARITY_EN
            r_par    <= r_par ^ i_bit;
`endif
            if (r_cnt == CNT_W'(CFG_SIZE - 1)) begin
              r_cnt <= '0;
`ifdef SB_CFG_PARITY_EN
              r_state <= ST_PAR;
`else
              r_state <= ST_COMMIT;
`endif
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
`ifdef SB_CFG_PARITY_EN
          ST_PAR: begin
            if (r_par ^ i_bit) begin
              r_err   <= 1'b1;
              r_state <= ST_IDLE;
            end else begin
              r_state <= ST_COMMIT;
            end
          end
`endif
          ST_COMMIT: r_state <= ST_IDLE;
          default:   r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign o_cfg   = r_active;
  assign o_valid = r_valid;
  assign o_busy  = (r_state != ST_IDLE);
  assign o_start = r_fwdStart;
  assign o_bit   = r_fwdBit;
`ifdef SB_CFG_PARITY_EN
  assign o_err   = r_err;
`else
  assign o_err   = 1'b0;
`endif

endmodule

// File: rtl/sb_cfg_gen2.sv
// Four-sided fabric switch box with per-track 2-bit selects driven by a
// daisy-chained config loader (optional parity via SB_CFG_PARITY_EN).
module sb_cfg_gen2
  import sb_cfg_pkg::*;
#(
  parameter int CHN_WIDTH = 16,
  parameter int ID_WIDTH  = 3,
  parameter int ID        = 5
) (
  input  logic                 clk,
  input  logic                 crst_n,
  input  logic [CHN_WIDTH-1:0] north_in,
  input  logic [CHN_WIDTH-1:0] east_in,
  input  logic [CHN_WIDTH-1:0] south_in,
  input  logic [CHN_WIDTH-1:0] west_in,
  output logic [CHN_WIDTH-1:0] north_out,
  output logic [CHN_WIDTH-1:0] east_out,
  output logic [CHN_WIDTH-1:0] south_out,
  output logic [CHN_WIDTH-1:0] west_out,
  input  logic                 cfg_in_start,
  input  logic                 cfg_bit_in,
  output logic                 cfg_out_start,
  output logic                 cfg_bit_out,
  output logic                 cfg_valid,
  output logic                 cfg_busy,
  output logic                 cfg_err
);

  localparam int CFG_SIZE = 8 * CHN_WIDTH;

  logic [CFG_SIZE-1:0]  w_cfg;
  logic [CHN_WIDTH-1:0] w_in  [NUM_SIDES];
  logic [CHN_WIDTH-1:0] w_out [NUM_SIDES];

  assign w_in[SIDE_N] = north_in;
  assign w_in[SIDE_E] = east_in;
  assign w_in[SIDE_S] = south_in;
  assign w_in[SIDE_W] = west_in;

  assign north_out = w_out[SIDE_N];
  assign east_out  = w_out[SIDE_E];
  assign south_out = w_out[SIDE_S];
  assign west_out  = w_out[SIDE_W];

  sb_cfg_loader #(
    .ID_WIDTH (ID_WIDTH),
    .ID       (ID),
    .CFG_SIZE (CFG_SIZE)
  ) u_loader (
    .clk     (clk),
    .crst_n  (crst_n),
    .i_start (cfg_in_start),
    .i_bit   (cfg_bit_in),
    .o_start (cfg_out_start),
    .o_bit   (cfg_bit_out),
    .o_valid (cfg_valid),
    .o_busy  (cfg_busy),
    .o_err   (cfg_err),
    .o_cfg   (w_cfg)
  );

  // Only clockwise neighbours are selectable, so a U-turn cannot be encoded.
  for (genvar s = 0; s < NUM_SIDES; s++) begin : g_side
    localparam int CW1 = cwSide(s, 1);
    localparam int CW2 = cwSide(s, 2);
    localparam int CW3 = cwSide(s, 3);
    for (genvar t = 0; t < CHN_WIDTH; t++) begin : g_track
      logic [1:0] w_sel;
      assign w_sel = w_cfg[2*(s*CHN_WIDTH+t) +: 2];
      assign w_out[s][t] = (w_sel == SEL_CW1) ? w_in[CW1][t] :
                           (w_sel == SEL_CW2) ? w_in[CW2][t] :
                           (w_sel == SEL_CW3) ? w_in[CW3][t] : 1'b0;
    end
  end

endmodule

// File: tb/tb_sb_cfg_gen2.sv
// Directed self-checking bench for sb_cfg_gen2 (CHN_WIDTH=4, ID_WIDTH=3, ID=5).
// Parity scenarios run only when SB_CFG_PARITY_EN is defined.
module tb_sb_cfg_gen2;

  logic       clk = 1'b0;
  logic       crst_n;
  logic [3:0] north_in, east_in, south_in, west_in;
  logic [3:0] north_out, east_out, south_out, west_out;
  logic       cfg_in_start, cfg_bit_in;
  logic       cfg_out_start, cfg_bit_out;
  logic       cfg_valid, cfg_busy, cfg_err;

  int total = 0;
  int bad   = 0;

  // Running tallies folded into single comparisons at chosen points.
  int          fwdBad    = 0;
  int          watchBad  = 0;
  int          watchSkip = 0;
  logic        watchEn   = 1'b0;
  logic [31:0] watchVal  = '0;
  logic        lastStart = 1'b0;
  logic        lastBit   = 1'b0;
  logic [31:0] allOuts;

  assign allOuts = {16'h0, north_out, east_out, south_out, west_out};

  always #5 clk = ~clk;

  sb_cfg_gen2 #(
    .CHN_WIDTH (4),
    .ID_WIDTH  (3),
    .ID        (5)
  ) dut (
    .clk           (clk),
    .crst_n        (crst_n),
    .north_in      (north_in),
    .east_in       (east_in),
    .south_in      (south_in),
    .west_in       (west_in),
    .north_out     (north_out),
    .east_out      (east_out),
    .south_out     (south_out),
    .west_out      (west_out),
    .cfg_in_start  (cfg_in_start),
    .cfg_bit_in    (cfg_bit_in),
    .cfg_out_start (cfg_out_start),
    .cfg_bit_out   (cfg_bit_out),
    .cfg_valid     (cfg_valid),
    .cfg_busy      (cfg_busy),
    .cfg_err       (cfg_err)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one config bit on the falling edge, first checking that the previous
  // bit was forwarded and, when enabled, that routing has not moved.
  task automatic applyStimulus(input logic s, input logic b);
    @(negedge clk);
    if ({cfg_out_start, cfg_bit_out} !== {lastStart, lastBit}) fwdBad++;
    if (watchEn) begin
      if (watchSkip > 0) watchSkip--;
      else if (allOuts !== watchVal) watchBad++;
    end
    cfg_in_start = s;
    cfg_bit_in   = b;
    lastStart    = s;
    lastBit      = b;
  endtask

  task automatic sendBits(input logic [2:0] hdr, input logic [31:0] pl, input int nPl);
    for (int i = 2; i >= 0; i--) applyStimulus(i == 2, hdr[i]);
    for (int i = 31; i > 31 - nPl; i--) applyStimulus(1'b0, pl[i]);
  endtask

  task automatic sendFrame(input logic [2:0] hdr, input logic [31:0] pl);
    sendBits(hdr, pl, 32);
`ifdef SB_CFG_PARITY_EN
    applyStimulus(1'b0, ^pl);
`endif
  endtask

  initial begin
`ifdef SB_CFG_PARITY_EN
    logic [31:0] badPl;
`endif
    crst_n       = 1'b0;
    cfg_in_start = 1'b0;
    cfg_bit_in   = 1'b1;
    north_in = 4'hF; east_in = 4'hA; south_in = 4'h0; west_in = 4'h0;
    #12;
    checkOutput("reset_outs",   allOuts, 32'h0);
    checkOutput("reset_valid",  32'(cfg_valid), 32'h0);
    checkOutput("reset_busy",   32'(cfg_busy), 32'h0);
    checkOutput("reset_err",    32'(cfg_err), 32'h0);
    checkOutput("reset_fwd",    32'({cfg_out_start, cfg_bit_out}), 32'h0);
    cfg_bit_in = 1'b0;
    @(negedge clk);
    crst_n = 1'b1;

    $display("[TB] matched frame, header 101, N takes E");
    sendFrame(3'b101, 32'h0000_0055);
    applyStimulus(1'b0, 1'b0);
    checkOutput("commit_busy",  32'(cfg_busy), 32'h1);
    checkOutput("commit_old",   allOuts, 32'h0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("match_valid",  32'(cfg_valid), 32'h1);
    checkOutput("match_idle",   32'(cfg_busy), 32'h0);
    checkOutput("match_route",  allOuts, 32'hA000);
    checkOutput("match_fwd",    32'(fwdBad), 32'h0);

    $display("[TB] unmatched header 011");
    watchVal = 32'hA000; watchEn = 1'b1;
    sendFrame(3'b011, 32'hFFFF_FFFF);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    watchEn = 1'b0;
    checkOutput("nomatch_busy",  32'(cfg_busy), 32'h0);
    checkOutput("nomatch_route", allOuts, 32'hA000);
    checkOutput("nomatch_hold",  32'(watchBad), 32'h0);
    checkOutput("nomatch_fwd",   32'(fwdBad), 32'h0);

    $display("[TB] broadcast header 111, mixed selects");
    north_in = 4'h6; east_in = 4'h9; south_in = 4'hC; west_in = 4'h3;
    sendFrame(3'b111, 32'h93FF_55FF);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("bcast_route", allOuts, 32'h3C9C);
    checkOutput("bcast_valid", 32'(cfg_valid), 32'h1);
    west_in = 4'h5;
    #1;
    checkOutput("comb_path", allOuts, 32'h5C9C);
    west_in = 4'h3;
    #1;

    $display("[TB] abort at payload bit 10, then new frame");
    watchVal = 32'h3C9C; watchEn = 1'b1;
    sendBits(3'b101, 32'hFFFF_FFAA, 10);
    sendFrame(3'b101, 32'h0000_0055);
    applyStimulus(1'b0, 1'b0);
    watchEn = 1'b0;
    checkOutput("abort_hold",  32'(watchBad), 32'h0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("abort_route", allOuts, 32'h9000);
    checkOutput("abort_fwd",   32'(fwdBad), 32'h0);

    $display("[TB] back-to-back frames, second start in COMMIT");
    sendFrame(3'b101, 32'h0000_00FF);
    watchVal = 32'h3000; watchSkip = 1; watchEn = 1'b1;
    sendFrame(3'b101, 32'h0000_5500);
    applyStimulus(1'b0, 1'b0);
    watchEn = 1'b0;
    checkOutput("b2b_first",  32'(watchBad), 32'h0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("b2b_second", allOuts, 32'h0C00);
    checkOutput("b2b_valid",  32'(cfg_valid), 32'h1);

`ifdef SB_CFG_PARITY_EN
    $display("[TB] bad parity then good frame");
    badPl = 32'hFF00_0000;
    sendBits(3'b101, badPl, 32);
    applyStimulus(1'b0, ~(^badPl));
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("par_err",   32'(cfg_err), 32'h1);
    checkOutput("par_hold",  allOuts, 32'h0C00);
    sendFrame(3'b101, 32'h00FF_0000);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("par_good",  allOuts, 32'h0090);
    checkOutput("par_stick", 32'(cfg_err), 32'h1);
`endif

    $display("[TB] reset asserted mid-LOAD");
    sendBits(3'b101, 32'hFFFF_FFFF, 5);
    @(negedge clk);
    checkOutput("load_busy", 32'(cfg_busy), 32'h1);
    #1;
    crst_n = 1'b0;
    #1;
    checkOutput("rst_outs",  allOuts, 32'h0);
    checkOutput("rst_valid", 32'(cfg_valid), 32'h0);
    checkOutput("rst_busy",  32'(cfg_busy), 32'h0);
    checkOutput("rst_err",   32'(cfg_err), 32'h0);
    checkOutput("rst_fwd",   32'({cfg_out_start, cfg_bit_out}), 32'h0);
    cfg_in_start = 1'b0; cfg_bit_in = 1'b0;
    lastStart = 1'b0; lastBit = 1'b0; fwdBad = 0;
    @(negedge clk);
    crst_n = 1'b1;
    sendFrame(3'b101, 32'h0000_0055);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("post_rst_route", allOuts, 32'h9000);
    checkOutput("post_rst_valid", 32'(cfg_valid), 32'h1);
    checkOutput("post_rst_fwd",   32'(fwdBad), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
